// File: rtl/mmu_port_arbiter.sv
// Single-port SRAM arbiter/sequencer between the fetch (IF) and load/store (MEM) requesters.
// Optional starvation guard for IF is enabled by defining MMU_ARB_STARVE_GUARD_EN.
module mmu_port_arbiter #(
    parameter int unsigned SRAM_LAT   = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        soc_clk,
    input  logic        MMU_reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_be,
    input  logic        mem_rw,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        sram_en,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [3:0]  sram_be,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned STV_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_owner_mem;
    logic               r_if_ack;
    logic               r_mem_ack;
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_mem_rdata;
    logic               r_sram_en;
    logic               r_sram_we;
    logic [31:0]        r_sram_addr;
    logic [3:0]         r_sram_be;
    logic [31:0]        r_sram_wdata;
    logic               r_busy;
    logic               w_pick_mem;
    logic               w_any_req;
    logic               w_unused;

    assign w_any_req = if_req | mem_req;

`ifdef MMU_ARB_STARVE_GUARD_EN
    logic [STV_W-1:0]   r_starve;

    // IF is forced through once MEM has won STARVE_MAX contested grants in a row
    assign w_pick_mem = mem_req && !(if_req && (r_starve == STV_W'(STARVE_MAX)));

    always_ff @(posedge soc_clk) begin
        if (MMU_reset) begin
            r_starve <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            if (!w_pick_mem) begin
                r_starve <= '0;
            end else if (if_req) begin
                r_starve <= r_starve + STV_W'(1);
            end
        end
    end

    assign w_unused = ^if_addr[1:0];
`else
    assign w_pick_mem = mem_req;
    assign w_unused   = ^{if_addr[1:0], STV_W'(STARVE_MAX)};
`endif

    always_ff @(posedge soc_clk) begin
        if (MMU_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_owner_mem  <= 1'b0;
            r_if_ack     <= 1'b0;
            r_mem_ack    <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_be    <= '0;
            r_sram_wdata <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_sram_en <= 1'b0;
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_mem <= w_pick_mem;
                        if (w_pick_mem) begin
                            r_sram_addr  <= mem_addr;
                            r_sram_be    <= mem_be;
                            r_sram_we    <= mem_rw;
                            r_sram_wdata <= mem_wdata;
                        end else begin
                            r_sram_addr  <= {if_addr[31:2], 2'b00};
                            r_sram_be    <= 4'b1111;
                            r_sram_we    <= 1'b0;
                        end
                        r_sram_en <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CNT_W'(SRAM_LAT - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        // read data lands in the owner's register; writes leave both untouched
                        if (!r_sram_we) begin
                            if (r_owner_mem) r_mem_rdata <= sram_rdata;
                            else             r_if_rdata  <= sram_rdata;
                        end
                        r_mem_ack <= r_owner_mem;
                        r_if_ack  <= ~r_owner_mem;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign if_ack     = r_if_ack;
    assign if_rdata   = r_if_rdata;
    assign mem_ack    = r_mem_ack;
    assign mem_rdata  = r_mem_rdata;
    assign sram_en    = r_sram_en;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_be    = r_sram_be;
    assign sram_wdata = r_sram_wdata;
    assign busy       = r_busy;

endmodule
